// File: rtl/column_pkg.sv
// Shared constants for the column puzzle datapath: ASCII codes, operator
// encoding and the token parser state encoding.
package column_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        IN_NUM,
        PEND_OP,
        PEND_DONE,
        FLUSH_NUM,
        FLUSH_DONE,
        FIN
    } state_t;

endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: acc <= acc*10 + digit, with a combinational
// flag that the pending load does not fit in NUM_W bits.
module dec_accum #(
    parameter int NUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [3:0]       digit,
    output logic [NUM_W-1:0] acc,
    output logic             ovf
);

    logic [NUM_W+3:0] next_wide;

    // acc*10 built from shifts; NUM_W+4 bits holds (2^NUM_W-1)*10+9 exactly.
    function automatic logic [NUM_W+3:0] mul10_add(input logic [NUM_W-1:0] a,
                                                   input logic [3:0] d);
        logic [NUM_W+3:0] a_ext;
        a_ext = {4'b0000, a};
        return (a_ext << 3) + (a_ext << 1) + {{NUM_W{1'b0}}, d};
    endfunction

    always_comb begin
        next_wide = mul10_add(acc, digit);
        ovf       = |next_wide[NUM_W+3:NUM_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= next_wide[NUM_W-1:0];
        end
    end

endmodule

// File: rtl/column_token_parser.sv
// Byte-stream tokenizer feeding the column reducer: decimal operands,
// '+'/'*' operators and end-of-column pulses, at most one token per cycle.
module column_token_parser
    import column_pkg::*;
#(
    parameter int NUM_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic             byte_ready,
    input  logic             eof,
    output logic             num_valid,
    output logic [NUM_W-1:0] num_in,
    output logic             op_valid,
    output logic             op_in,
    output logic             done,
    output logic [CNT_W-1:0] col_count,
    output logic             overflow,
    output logic             bad_char,
    output logic             finished
);

    state_t           state, state_nxt;
    logic             op_seen, op_seen_nxt;
    logic             pend_op, pend_op_nxt;
    logic             num_valid_nxt, op_valid_nxt, op_in_nxt, done_nxt;
    logic [NUM_W-1:0] num_in_nxt;
    logic [CNT_W-1:0] col_count_nxt;
    logic             bad_char_nxt, finished_nxt;
    logic             acc_clear, acc_load, acc_ovf;
    logic [NUM_W-1:0] acc;
    logic             in_num, is_digit, is_op, op_code;

    dec_accum #(.NUM_W(NUM_W)) u_dec_accum (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .load  (acc_load),
        .digit (byte_in[3:0]),
        .acc   (acc),
        .ovf   (acc_ovf)
    );

    assign byte_ready = (state == IDLE) || (state == IN_NUM);
    assign in_num     = (state == IN_NUM);
    assign is_digit   = (byte_in >= CH_0) && (byte_in <= CH_9);
    assign is_op      = (byte_in == CH_PLUS) || (byte_in == CH_STAR);
    assign op_code    = (byte_in == CH_STAR) ? OP_MUL : OP_ADD;

    always_comb begin
        state_nxt     = state;
        op_seen_nxt   = op_seen;
        pend_op_nxt   = pend_op;
        num_valid_nxt = 1'b0;
        num_in_nxt    = num_in;
        op_valid_nxt  = 1'b0;
        op_in_nxt     = op_in;
        done_nxt      = 1'b0;
        col_count_nxt = col_count;
        bad_char_nxt  = bad_char;
        finished_nxt  = finished;
        acc_clear     = 1'b0;
        acc_load      = 1'b0;

        case (state)
            IDLE, IN_NUM: begin
                if (eof) begin
                    if (in_num) begin
                        state_nxt = FLUSH_NUM;
                    end else if (op_seen) begin
                        state_nxt = FLUSH_DONE;
                    end else begin
                        state_nxt    = FIN;
                        finished_nxt = 1'b1;
                    end
                end else if (byte_valid) begin
                    if (is_digit) begin
                        acc_load  = 1'b1;
                        state_nxt = IN_NUM;
                    end else if (is_op) begin
                        if (in_num) begin
                            // Operand goes out first; the operator waits one cycle.
                            num_valid_nxt = 1'b1;
                            num_in_nxt    = acc;
                            acc_clear     = 1'b1;
                            pend_op_nxt   = op_code;
                            state_nxt     = PEND_OP;
                        end else begin
                            op_valid_nxt = 1'b1;
                            op_in_nxt    = op_code;
                            op_seen_nxt  = 1'b1;
                        end
                    end else if (byte_in == CH_LF) begin
                        if (in_num) begin
                            num_valid_nxt = 1'b1;
                            num_in_nxt    = acc;
                            acc_clear     = 1'b1;
                            state_nxt     = op_seen ? PEND_DONE : IDLE;
                        end else if (op_seen) begin
                            done_nxt      = 1'b1;
                            col_count_nxt = col_count + CNT_W'(1);
                            op_seen_nxt   = 1'b0;
                        end
                    end else begin
                        // Space, CR and unsupported bytes all end an operand.
                        if ((byte_in != CH_SPACE) && (byte_in != CH_CR)) begin
                            bad_char_nxt = 1'b1;
                        end
                        if (in_num) begin
                            num_valid_nxt = 1'b1;
                            num_in_nxt    = acc;
                            acc_clear     = 1'b1;
                            state_nxt     = IDLE;
                        end
                    end
                end
            end
            PEND_OP: begin
                op_valid_nxt = 1'b1;
                op_in_nxt    = pend_op;
                op_seen_nxt  = 1'b1;
                state_nxt    = IDLE;
            end
            PEND_DONE: begin
                done_nxt      = 1'b1;
                col_count_nxt = col_count + CNT_W'(1);
                op_seen_nxt   = 1'b0;
                state_nxt     = IDLE;
            end
            FLUSH_NUM: begin
                num_valid_nxt = 1'b1;
                num_in_nxt    = acc;
                acc_clear     = 1'b1;
                if (op_seen) begin
                    state_nxt = FLUSH_DONE;
                end else begin
                    state_nxt    = FIN;
                    finished_nxt = 1'b1;
                end
            end
            FLUSH_DONE: begin
                done_nxt      = 1'b1;
                col_count_nxt = col_count + CNT_W'(1);
                op_seen_nxt   = 1'b0;
                state_nxt     = FIN;
                finished_nxt  = 1'b1;
            end
            FIN: begin
                state_nxt = FIN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            op_seen   <= 1'b0;
            pend_op   <= 1'b0;
            num_valid <= 1'b0;
            num_in    <= '0;
            op_valid  <= 1'b0;
            op_in     <= 1'b0;
            done      <= 1'b0;
            col_count <= '0;
            overflow  <= 1'b0;
            bad_char  <= 1'b0;
            finished  <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_seen   <= op_seen_nxt;
            pend_op   <= pend_op_nxt;
            num_valid <= num_valid_nxt;
            num_in    <= num_in_nxt;
            op_valid  <= op_valid_nxt;
            op_in     <= op_in_nxt;
            done      <= done_nxt;
            col_count <= col_count_nxt;
            overflow  <= overflow | (acc_load & acc_ovf);
            bad_char  <= bad_char_nxt;
            finished  <= finished_nxt;
        end
    end

endmodule

// File: tb/tb_column_token_parser.sv
// Directed bench for column_token_parser: byte strings in, token event log
// compared against hand-computed sequences.
module tb_column_token_parser;

    localparam int NUM_W = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_in = 8'h00;
    logic             eof = 1'b0;
    logic             byte_ready;
    logic             num_valid;
    logic [NUM_W-1:0] num_in;
    logic             op_valid;
    logic             op_in;
    logic             done;
    logic [CNT_W-1:0] col_count;
    logic             overflow;
    logic             bad_char;
    logic             finished;

    column_token_parser #(.NUM_W(NUM_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .byte_ready (byte_ready),
        .eof        (eof),
        .num_valid  (num_valid),
        .num_in     (num_in),
        .op_valid   (op_valid),
        .op_in      (op_in),
        .done       (done),
        .col_count  (col_count),
        .overflow   (overflow),
        .bad_char   (bad_char),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int excl_viol = 0;
    int rdy_low = 0;
    int          ev_kind[$];
    logic [31:0] ev_val[$];
    int          ev_cyc[$];

    localparam int EV_NUM  = 1;
    localparam int EV_OP   = 2;
    localparam int EV_DONE = 3;

    always @(posedge clk) cyc <= cyc + 1;

    // Token log, sampled mid-cycle.
    always @(negedge clk) begin
        if (num_valid) begin
            ev_kind.push_back(EV_NUM); ev_val.push_back(num_in); ev_cyc.push_back(cyc);
        end
        if (op_valid) begin
            ev_kind.push_back(EV_OP); ev_val.push_back({31'd0, op_in}); ev_cyc.push_back(cyc);
        end
        if (done) begin
            ev_kind.push_back(EV_DONE); ev_val.push_back(32'd0); ev_cyc.push_back(cyc);
        end
        if ((int'(num_valid) + int'(op_valid) + int'(done)) > 1) excl_viol++;
        if (!byte_ready) rdy_low++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input int idx, input int kind, input logic [31:0] val);
        check({tag, "_kind"}, ev_kind.size() > idx ? ev_kind[idx] : -1, kind);
        check({tag, "_val"}, ev_kind.size() > idx ? ev_val[idx] : 32'hFFFF_FFFF, val);
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        for (int i = 0; i < budget; i++) begin
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        bit ok;
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 20, ok);
            if (!ok) check("accept_timeout", ok, 1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_ev();
        @(posedge clk);
        #1;
        ev_kind.delete();
        ev_val.delete();
        ev_cyc.delete();
        rdy_low = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_num_valid", num_valid, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_done", done, 0);
        check("rst_num_in", num_in, 0);
        check("rst_col_count", col_count, 0);
        check("rst_flags", {overflow, bad_char, finished}, 0);
        check("rst_ready", byte_ready, 1);

        // Three operands, a multiply operator, end of column.
        clear_ev();
        send_str("123 45 6\n*\n");
        idle(3);
        check("t1_count", ev_kind.size(), 5);
        expect_ev("t1_e0", 0, EV_NUM, 123);
        expect_ev("t1_e1", 1, EV_NUM, 45);
        expect_ev("t1_e2", 2, EV_NUM, 6);
        expect_ev("t1_e3", 3, EV_OP, 1);
        expect_ev("t1_e4", 4, EV_DONE, 0);
        check("t1_col_count", col_count, 1);
        check("t1_flags", {overflow, bad_char, finished}, 0);

        // Operator directly after a digit with valid held high.
        clear_ev();
        send_str("7+\n");
        idle(3);
        check("t2_count", ev_kind.size(), 3);
        expect_ev("t2_e0", 0, EV_NUM, 7);
        expect_ev("t2_e1", 1, EV_OP, 0);
        expect_ev("t2_e2", 2, EV_DONE, 0);
        check("t2_op_gap", ev_cyc[1] - ev_cyc[0], 1);
        check("t2_done_gap", ev_cyc[2] - ev_cyc[1], 1);
        check("t2_ready_low", rdy_low, 1);
        check("t2_col_count", col_count, 2);

        // 2^32 wraps to 0 and sets the sticky overflow flag.
        clear_ev();
        send_str("4294967296 ");
        idle(2);
        check("t3_overflow", overflow, 1);
        send_str("5 ");
        idle(2);
        check("t3_count", ev_kind.size(), 2);
        expect_ev("t3_e0", 0, EV_NUM, 0);
        expect_ev("t3_e1", 1, EV_NUM, 5);
        check("t3_overflow_sticky", overflow, 1);
        check("t3_bad_char", bad_char, 0);

        // Unsupported byte acts as a delimiter.
        clear_ev();
        send_str("9a3 ");
        idle(2);
        check("t5_bad_char", bad_char, 1);
        check("t5_count", ev_kind.size(), 2);
        expect_ev("t5_e0", 0, EV_NUM, 9);
        expect_ev("t5_e1", 1, EV_NUM, 3);

        // eof after an operator line flushes the done pulse and parks in FIN.
        clear_ev();
        send_str("12 *");
        eof = 1'b1;
        @(negedge clk);
        eof = 1'b0;
        idle(5);
        check("t4_count", ev_kind.size(), 3);
        expect_ev("t4_e0", 0, EV_NUM, 12);
        expect_ev("t4_e1", 1, EV_OP, 1);
        expect_ev("t4_e2", 2, EV_DONE, 0);
        check("t4_finished", finished, 1);
        check("t4_ready", byte_ready, 0);
        check("t4_col_count", col_count, 3);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = 8'h37;
        idle(4);
        byte_in    = 8'h20;
        idle(4);
        byte_valid = 1'b0;
        idle(2);
        check("t4_ignored", ev_kind.size(), 3);
        check("t4_finished_hold", finished, 1);

        // Mid-operand reset discards "88".
        do_reset();
        clear_ev();
        check("t6_finished_clr", finished, 0);
        send_str("88");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        send_str("5 ");
        idle(3);
        check("t6_count", ev_kind.size(), 1);
        expect_ev("t6_e0", 0, EV_NUM, 5);
        check("t6_col_count", col_count, 0);
        check("t6_flags", {overflow, bad_char, finished}, 0);

        check("exclusive_pulses", excl_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/column_token_parser.md
Name: column_token_parser

Overview:
- Upstream feeder of column_reducer_dual. Consumes the puzzle text as a byte stream, one ASCII byte per handshake.
- Converts decimal digit runs into 32-bit operands on num_valid/num_in and '+'/'*' into op_valid/op_in (0 = add, 1 = multiply).
- Pulses done when a column's operator line ends.
- Operand, op and done pulses are mutually exclusive per cycle, so the reducer never sees two tokens in one cycle.

Parameters:
- NUM_W, 32, operand width; must match reducer num_in width.
- CNT_W, 16, width of the completed-column counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk; 0 = reset).
- byte_valid  input  1  byte_in valid this cycle.
- byte_in  input  8  ASCII byte.
- byte_ready  output  1  parser accepts byte_in this cycle; transfer = byte_valid & byte_ready.
- eof  input  1  single-cycle pulse: end of stream. Honoured only when byte_ready=1; byte_valid must be 0 that cycle.
- num_valid  output  1  one-cycle operand pulse.
- num_in  output  NUM_W  operand value; held between pulses.
- op_valid  output  1  one-cycle operator pulse.
- op_in  output  1  0 = '+', 1 = '*'.
- done  output  1  one-cycle end-of-column pulse.
- col_count  output  CNT_W  number of done pulses issued; wraps at 2^CNT_W.
- overflow  output  1  sticky: an operand exceeded 2^NUM_W-1; the emitted value is mod 2^NUM_W.
- bad_char  output  1  sticky: an unsupported byte was received; the byte is otherwise ignored.
- finished  output  1  high after the eof flush completes; stays high until reset.

Behaviour:
- Reset (rst=0 at edge):
  - All pulse outputs, num_in, op_in, col_count, overflow, bad_char and finished = 0.
  - Accumulator cleared, op_seen = 0, state = IDLE, byte_ready = 1 the cycle after release.
- Reset mid-stream discards any partial operand and pending token without emitting them.
- States: IDLE, IN_NUM, PEND_OP, PEND_DONE, FLUSH_NUM, FLUSH_DONE, FIN.
- Digit '0'-'9' accepted:
  - acc <= acc*10 + d, computed at NUM_W+4 bits.
  - If any upper bit is set, overflow <= 1 and acc keeps the low NUM_W bits.
  - IDLE -> IN_NUM.
- Space (0x20) or CR (0x0D) in IN_NUM: num_valid=1, num_in=acc on the next edge (latency 1); acc cleared; -> IDLE. In IDLE these bytes are ignored.
- '+'/'*' in IDLE: op_valid=1, op_in set on the next edge, op_seen <= 1.
- '+'/'*' in IN_NUM:
  - Operand is emitted first; state -> PEND_OP with the op latched.
  - byte_ready=0 for one cycle, then op_valid.
  - Operand always precedes the operator.
- LF (0x0A):
  - In IDLE with op_seen=1: done pulse, col_count++, op_seen <= 0.
  - In IN_NUM: the operand is emitted. If op_seen=1, -> PEND_DONE (ready low one cycle, then done). Otherwise -> IDLE.
  - LF with op_seen=0 and no pending operand: no output.
- Any other byte: bad_char <= 1; treated as a delimiter (flushes any operand, like space).
- eof while byte_ready=1:
  - IN_NUM -> FLUSH_NUM (emit operand); then FLUSH_DONE if op_seen; then FIN.
  - IDLE: FLUSH_DONE if op_seen, else FIN directly.
  - byte_ready=0 in all flush states and FIN.
  - finished=1 on entry to FIN.
- byte_ready=0 in PEND_*, FLUSH_* and FIN, and exactly one cycle in each PEND state. Bytes presented while ready=0 are not consumed.
- No two of num_valid/op_valid/done are ever high in the same cycle.
- An operand of 0 (e.g. "0 ") is emitted normally. Leading zeros are accepted.
- The parser never back-pressures on downstream; the reducer is always-ready.

Decomposition:
- Shared package column_pkg:
  - ASCII constants CH_SPACE, CH_LF, CH_CR, CH_PLUS, CH_STAR, CH_0, CH_9.
  - OP_ADD=0, OP_MUL=1 (shared with column_reducer_dual).
  - State enum.
- One natural sub-module: dec_accum.
  - Contents: acc*10+d datapath with clear/load and overflow detect.
  - Function: combinational next-value plus registered acc.

Test Plan:
- Feed "123 45 6\n*\n" -> num pulses 123, 45, 6 in order; op_valid with op_in=1; then done; col_count=1; no flags.
- Feed "7+\n", byte_valid held high -> num 7, byte_ready low exactly one cycle, op_in=0 next cycle, done after LF; pulses on distinct cycles.
- Feed "4294967296 " -> overflow=1, num_in=0 emitted; then "5 " -> num_in=5, overflow still 1.
- Feed "12 *" then eof -> num 12, op_valid(op_in=1), done, finished=1, byte_ready stays 0; further bytes ignored.
- Feed "9a3 " -> bad_char=1, num 9 then num 3.
- Feed "88", assert rst=0 for one cycle, then "5 " -> only num_in=5 emitted; col_count=0, flags cleared.
